load_use_scoreboard: RTL and testbench

Per-register result-latency scoreboard in the decode stage. It is the producer-side counterpart to the EX/MEM/WB bypass network. At issue it records each destination register and the number of cycles until that result becomes forwardable. It then holds back any consumer that would read a value the bypass paths cannot yet supply, such as load-use or multi-cycle results. It also counts stall cycles for performance reporting.

---
 rtl/load_use_scoreboard.sv | 53 +++++
 tb/tb_load_use_scoreboard.sv | 138 +++++++++++++
 2 files changed

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: per-register result-latency countdown that stalls decode on unforwardable hazards
module load_use_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LAT_W = 3,
    parameter int CNT_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                id_wr_en,
    input  logic [4:0]          id_dest_reg_idx,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                pipe_hold,
    input  logic                flush,
    output logic                stall,
    output logic                busy_rs1,
    output logic                busy_rs2,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic [CNT_W-1:0]    stall_cycles
);
    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic waw, issue;
    always_comb begin
        busy_rs1 = id_valid && id_uses_rs1 && id_rs1 != 5'd0 && cnt[id_rs1] != '0;
        busy_rs2 = id_valid && id_uses_rs2 && id_rs2 != 5'd0 && cnt[id_rs2] != '0;
        waw = id_valid && id_wr_en && id_dest_reg_idx != 5'd0 && cnt[id_dest_reg_idx] != '0;
        stall = busy_rs1 || busy_rs2 || waw;
        issue = id_valid && !stall && !pipe_hold && !flush;
        for (int i = 0; i < NUM_REGS; i++)
            pending_mask[i] = cnt[i] != '0;
    end
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_REGS; i++)
                cnt[i] <= '0;
        end else if (!pipe_hold) begin
            cnt[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++)
                cnt[i] <= (issue && id_wr_en && id_dest_reg_idx == 5'(i)) ? id_lat :
                          (cnt[i] != '0) ? cnt[i] - 1'b1 : '0;
        end
    end
    always_ff @(posedge clock) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall && !pipe_hold && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: directed vector table, random run against a counter model, and counter saturation
module tb_load_use_scoreboard;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, id_valid, id_uses_rs1, id_uses_rs2, id_wr_en, pipe_hold, flush;
    logic [4:0] id_rs1, id_rs2, id_dest_reg_idx;
    logic [2:0] id_lat;
    logic stall, busy_rs1, busy_rs2, stall4, busy4_1, busy4_2;
    logic [31:0] pending_mask, pending4, stall_cycles;
    logic [3:0] stall_cycles4;

    load_use_scoreboard dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_wr_en(id_wr_en),
        .id_dest_reg_idx(id_dest_reg_idx), .id_lat(id_lat), .pipe_hold(pipe_hold), .flush(flush),
        .stall(stall), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .pending_mask(pending_mask),
        .stall_cycles(stall_cycles)
    );

    load_use_scoreboard #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_wr_en(id_wr_en),
        .id_dest_reg_idx(id_dest_reg_idx), .id_lat(id_lat), .pipe_hold(pipe_hold), .flush(flush),
        .stall(stall4), .busy_rs1(busy4_1), .busy_rs2(busy4_2), .pending_mask(pending4),
        .stall_cycles(stall_cycles4)
    );

    int pass_n = 0, tot_n = 0;
    int m_cnt [32];
    longint n_st = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tot_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic longint sat(input longint v, input longint mx);
        return v > mx ? mx : v;
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic u1, input logic u2, input logic w, input logic [4:0] d,
                       input logic [2:0] l, input logic h, input logic f, input bit do_chk);
        logic mb1, mb2, mw, ms;
        longint pm;
        @(negedge clock);
        reset = r; id_valid = v; id_rs1 = a; id_rs2 = b; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_wr_en = w; id_dest_reg_idx = d; id_lat = l; pipe_hold = h; flush = f;
        #1;
        mb1 = v && u1 && a != 0 && m_cnt[a] > 0;
        mb2 = v && u2 && b != 0 && m_cnt[b] > 0;
        mw = v && w && d != 0 && m_cnt[d] > 0;
        ms = mb1 || mb2 || mw;
        pm = 0;
        for (int i = 0; i < 32; i++) if (m_cnt[i] > 0) pm |= longint'(1) << i;
        if (do_chk) begin
            chk("stall", stall, ms);
            chk("busy_rs1", busy_rs1, mb1);
            chk("busy_rs2", busy_rs2, mb2);
            chk("pending_mask", pending_mask, pm);
            chk("stall_cycles", stall_cycles, sat(n_st, 64'hFFFF_FFFF));
            chk("stall_cycles_w4", stall_cycles4, sat(n_st, 15));
            chk("stall_w4", stall4, ms);
        end
        if (r) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            n_st = 0;
        end else begin
            if (ms && !h) n_st++;
            if (f) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else if (!h) begin
                for (int i = 0; i < 32; i++) if (m_cnt[i] > 0) m_cnt[i]--;
                if (v && !ms && w && d != 0) m_cnt[d] = l;
            end
        end
    endtask

    typedef struct {
        logic v; logic [4:0] a, b; logic u1, u2, w; logic [4:0] d; logic [2:0] l; logic h, f;
        logic es; logic [31:0] epm; int esc;
    } vec_t;
    vec_t tbl [18];

    initial begin
        tbl = '{
            '{1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 32'h0,   0},
            '{1, 5, 0, 1, 0, 1, 6, 0, 0, 0, 1, 32'h20,  0},
            '{1, 5, 0, 1, 0, 1, 6, 0, 0, 0, 0, 32'h0,   1},
            '{1, 0, 0, 0, 0, 1, 7, 3, 0, 0, 0, 32'h0,   1},
            '{1, 0, 7, 0, 1, 1, 8, 0, 0, 0, 1, 32'h80,  1},
            '{1, 0, 7, 0, 1, 1, 8, 0, 1, 0, 1, 32'h80,  2},
            '{1, 0, 7, 0, 1, 1, 8, 0, 0, 0, 1, 32'h80,  2},
            '{1, 0, 7, 0, 1, 1, 8, 0, 0, 0, 1, 32'h80,  3},
            '{1, 0, 7, 0, 1, 1, 8, 0, 0, 0, 0, 32'h0,   4},
            '{1, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 32'h0,   4},
            '{1, 0, 0, 1, 1, 1, 0, 5, 0, 0, 0, 32'h0,   4},
            '{1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0,   4},
            '{1, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,   4},
            '{1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 32'h0,   4},
            '{1, 0, 0, 0, 0, 1, 9, 1, 0, 1, 1, 32'h200, 4},
            '{1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, 32'h0,   5},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 5},
            '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   5}
        };
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        cyc(1, 0, 5'($urandom), 5'($urandom), 1, 1, 1, 5'($urandom), 3'($urandom), 0, 0, 0);
        cyc(1, 0, 5'($urandom), 5'($urandom), 1, 1, 1, 5'($urandom), 3'($urandom), 0, 0, 1);
        chk("reset_pending", pending_mask, 0);
        chk("reset_stall", stall, 0);
        chk("reset_stall_cycles", stall_cycles, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("idle_stall_cycles", stall_cycles, 0);
        for (int i = 0; i < 18; i++) begin
            cyc(0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].u1, tbl[i].u2, tbl[i].w, tbl[i].d,
                tbl[i].l, tbl[i].h, tbl[i].f, 1);
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].es);
            chk($sformatf("vec%0d_pending", i), pending_mask, tbl[i].epm);
            chk($sformatf("vec%0d_stall_cycles", i), stall_cycles, tbl[i].esc);
        end
        for (int n = 0; n < 1500; n++)
            cyc($urandom_range(99) < 2, $urandom_range(9) < 8, 5'($urandom_range(7)),
                5'($urandom_range(7)), 1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom_range(7)), 3'($urandom), $urandom_range(9) == 0,
                $urandom_range(19) == 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 21; n++)
            cyc(0, 1, 1, 0, 1, 0, 1, 1, 7, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("sat_w4", stall_cycles4, 15);
        chk("sat_w32", stall_cycles, 18);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
